ula_ctrl: RTL

Register-file and sequencing stage that sits directly upstream of the ULA. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an 8 x 16-bit register bank. It drives the ULA's `in_a`/`in_b`/`op_select` inputs, captures the ULA result and writes it back to the bank. Immediate-load and move instructions bypass the ULA.

---
 rtl/ula_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ula_ctrl.sv
// ---------------------------------------------------------------------------
// ula_ctrl
//
// Register-file and sequencing stage placed in front of the ULA. It accepts
// 16-bit instructions over a valid/ready handshake and holds an
// NREGS x WIDTH register bank. ALU instructions drive the ULA operands and
// capture its result. LDI and MOV bypass the ULA. Every instruction ends in
// a one-cycle WB state, where the result is written back and `done` pulses.
//
// Instruction word:
//   [15:14] opcode  00 NOP | 01 LDI | 10 ALU | 11 MOV
//   [13:11] rd
//   [10:8]  ra
//   [7:5]   rb
//   [7:0]   imm8    (LDI, zero-extended)
//   [0]     op bit  (ALU, drives op_select)
//
// Ports:
//   clk          single clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   instr        instruction word
//   instr_valid  instr is valid this cycle
//   instr_ready  high only in IDLE (registered)
//   in_a, in_b   ULA operands (registered; change only on ALU acceptance)
//   op_select    ULA operation select (registered)
//   ula_out      combinational ULA result, sampled at the end of EXEC
//   done         one-cycle pulse while the instruction is in WB
//   dbg_addr     debug read address
//   dbg_data     combinational read of regs[dbg_addr]
//
// Latency from the acceptance edge:
//   ALU      EXEC, then WB (done). The register is visible three cycles later.
//   LDI/MOV  WB (done). The register is visible two cycles later.
//   NOP      WB (done) with the write disabled.
// ---------------------------------------------------------------------------
module ula_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] in_a,
    output logic [WIDTH-1:0] in_b,
    output logic             op_select,
    input  logic [WIDTH-1:0] ula_out,
    output logic             done,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    // Instruction field helpers
    function automatic logic [1:0] f_opcode(input logic [15:0] w);
        return w[15:14];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] w);
        return w[13:11];
    endfunction

    function automatic logic [2:0] f_ra(input logic [15:0] w);
        return w[10:8];
    endfunction

    function automatic logic [2:0] f_rb(input logic [15:0] w);
        return w[7:5];
    endfunction

    // imm8 is placed in the low byte with all upper bits cleared.
    function automatic logic [WIDTH-1:0] zext_imm8(input logic [15:0] w);
        logic [WIDTH-1:0] v;
        v      = '0;
        v[7:0] = w[7:0];
        return v;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] result;
    logic [2:0]       rd_q;
    logic             wr_en;

    // ----------------------------------------------------------------------
    // Sequencer: IDLE -> (EXEC ->) WB -> IDLE
    // Operands are read from the bank at acceptance. A source equal to rd
    // therefore sees the pre-write value, because the write happens in WB.
    // ----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            in_a        <= '0;
            in_b        <= '0;
            op_select   <= 1'b0;
            result      <= '0;
            rd_q        <= '0;
            wr_en       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (instr_valid) begin
                        instr_ready <= 1'b0;
                        rd_q        <= f_rd(instr);
                        case (f_opcode(instr))
                            OP_ALU: begin
                                in_a      <= regs[f_ra(instr)];
                                in_b      <= regs[f_rb(instr)];
                                op_select <= instr[0];
                                wr_en     <= 1'b1;
                                state     <= EXEC;
                            end
                            OP_LDI: begin
                                result <= zext_imm8(instr);
                                wr_en  <= 1'b1;
                                done   <= 1'b1;
                                state  <= WB;
                            end
                            OP_MOV: begin
                                result <= regs[f_ra(instr)];
                                wr_en  <= 1'b1;
                                done   <= 1'b1;
                                state  <= WB;
                            end
                            OP_NOP: begin
                                wr_en <= 1'b0;
                                done  <= 1'b1;
                                state <= WB;
                            end
                            default: begin
                                wr_en <= 1'b0;
                                done  <= 1'b1;
                                state <= WB;
                            end
                        endcase
                    end
                end

                // Operands have been stable for a full cycle. The ULA output
                // is captured at full width with no flag bits.
                EXEC: begin
                    result <= ula_out;
                    done   <= 1'b1;
                    state  <= WB;
                end

                WB: begin
                    if (wr_en) begin
                        regs[rd_q] <= result;
                    end
                    wr_en       <= 1'b0;
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    wr_en       <= 1'b0;
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Debug read port: combinational view of the bank.
    assign dbg_data = regs[dbg_addr];

    // Handshake and pulse invariants
    a_ready_done_excl : assert property (@(posedge clk) disable iff (rst)
        !(instr_ready && done));

    a_done_single : assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

endmodule
